// File: rtl/bcd2bin_pkg.sv
// Shared constants and FSM encoding for the BCD <-> binary converters.
// Default widths cover four BCD digits (0..9999) in 14 binary bits.
package bcd2bin_pkg;

    localparam int DEF_M = 16;
    localparam int DEF_N = 14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A BCD nibble is only legal for values 0..9.
    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd2bin_digit_fix.sv
// Per-digit correction for reverse double-dabble.
// A shifted digit >= 8 received a carried-in 8 that must become 5.
module bcd_digit_fix (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD to binary converter (reverse double-dabble).
// One result bit per cycle; N cycles from accept to DONE.
module bcd2bin
    import bcd2bin_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] bcd,
    output logic [N-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int D  = M / 4;
    localparam int CW = $clog2(N + 1);

    state_t          state;
    logic [M-1:0]    dig;
    logic [N-1:0]    sr;
    logic [CW-1:0]   cnt;
    logic            bad_pend;

    logic [M-1:0]    dig_sh;
    logic [M-1:0]    dig_nx;
    logic [N-1:0]    sr_nx;
    logic            bcd_bad;
    logic            last;

    assign dig_sh = dig >> 1;
    assign sr_nx  = {dig[0], sr[N-1:1]};
    assign last   = (cnt == CW'(N - 1));

    genvar g;
    generate
        for (g = 0; g < D; g++) begin : g_fix
            bcd_digit_fix u_fix (
                .digit (dig_sh[4*g +: 4]),
                .fixed (dig_nx[4*g +: 4])
            );
        end
    endgenerate

    // Flag an operand holding any non-decimal nibble.
    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (digit_bad(bcd[4*i +: 4])) bcd_bad = 1'b1;
        end
    end

    // Control FSM, datapath shift and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dig      <= '0;
            sr       <= '0;
            cnt      <= '0;
            bad_pend <= 1'b0;
            bin      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= S_CONV;
                        dig      <= bcd;
                        sr       <= '0;
                        cnt      <= '0;
                        bad_pend <= bcd_bad;
                        busy     <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (bad_pend) begin
                        // Illegal digit: report at once, no steps.
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        bin   <= '0;
                    end else begin
                        dig <= dig_nx;
                        sr  <= sr_nx;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            // Leftover digit weight means the value
                            // does not fit in N bits.
                            if (dig_nx != '0) begin
                                err <= 1'b1;
                                bin <= '0;
                            end else begin
                                err <= 1'b0;
                                bin <= sr_nx;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: default (N=14) and N=8 instances.
// Vector table, random operands vs arithmetic model, corner sequences.
module tb_bcd2bin;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] bcd_a, bcd_b;
    logic [13:0] bin_a;
    logic [7:0]  bin_b;
    logic        busy_a, done_a, err_a;
    logic        busy_b, done_b, err_b;

    int tests = 0;
    int fails = 0;

    bcd2bin u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_a),
        .bcd   (bcd_a),
        .bin   (bin_a),
        .busy  (busy_a),
        .done  (done_a),
        .err   (err_a)
    );

    bcd2bin #(.M(16), .N(8)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_b),
        .bcd   (bcd_b),
        .bin   (bin_b),
        .busy  (busy_b),
        .done  (done_b),
        .err   (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Decimal value from digits; illegal nibble or too large -> error.
    function automatic void model(input logic [15:0] v, input int n,
                                  output logic [13:0] b, output logic e,
                                  output int lat);
        int  val;
        bit  bad;
        val = 0;
        bad = 0;
        for (int i = 3; i >= 0; i--) begin
            if (v[4*i +: 4] > 4'd9) bad = 1;
            val = val * 10 + int'(v[4*i +: 4]);
        end
        if (bad) begin
            b = '0; e = 1'b1; lat = 1;
        end else if (val >= (1 << n)) begin
            b = '0; e = 1'b1; lat = n;
        end else begin
            b = 14'(val); e = 1'b0; lat = n;
        end
    endfunction

    function automatic logic [13:0] cur_bin(input bit sel);
        return sel ? {6'b0, bin_b} : bin_a;
    endfunction

    // One request from IDLE; returns result and accept-to-DONE latency.
    task automatic convert(input bit sel, input logic [15:0] v,
                           output logic [13:0] b, output logic e,
                           output int lat);
        logic [13:0] prev;
        bit          hold_ok;
        bit          got;
        @(negedge clk);
        if (sel) begin start_b = 1'b1; bcd_b = v; end
        else     begin start_a = 1'b1; bcd_a = v; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        bcd_a = 16'($urandom);
        bcd_b = 16'($urandom);
        check("busy_after_accept", sel ? busy_b : busy_a, 1);
        prev    = cur_bin(sel);
        hold_ok = 1;
        got     = 0;
        lat     = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel ? done_b : done_a) begin
                got = 1;
                break;
            end
            if (cur_bin(sel) !== prev) hold_ok = 0;
        end
        if (!got) begin
            $display("FAIL timeout: got no done expected done within 40");
            fails++;
            tests++;
            lat = 99;
        end
        check("bin_hold_in_conv", 32'(hold_ok), 1);
        check("busy_in_done", sel ? busy_b : busy_a, 1);
        b = cur_bin(sel);
        e = sel ? err_b : err_a;
        @(posedge clk);
        #1;
        check("done_single_cycle", sel ? done_b : done_a, 0);
        check("busy_fall", sel ? busy_b : busy_a, 0);
        check("bin_hold_idle", cur_bin(sel), b);
    endtask

    vec_t        vecs[$];
    logic [13:0] rb, eb;
    logic        re, ee;
    int          rl, el;
    logic [15:0] v;
    int          dcnt;
    int          dpos[$];

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        bcd_a   = '0;
        bcd_b   = '0;

        vecs.push_back('{16'h9999, 14'd9999, 1'b0, 14});
        vecs.push_back('{16'h0000, 14'd0,    1'b0, 14});
        vecs.push_back('{16'h1234, 14'd1234, 1'b0, 14});
        vecs.push_back('{16'h12A4, 14'd0,    1'b1, 1});
        vecs.push_back('{16'h0042, 14'd42,   1'b0, 14});
        vecs.push_back('{16'h0001, 14'd1,    1'b0, 14});
        vecs.push_back('{16'h8190, 14'd8190, 1'b0, 14});
        vecs.push_back('{16'hF000, 14'd0,    1'b1, 1});
        vecs.push_back('{16'h000A, 14'd0,    1'b1, 1});

        repeat (2) @(posedge clk);
        #1;
        check("rst_bin", bin_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            convert(0, vecs[i].bcd, rb, re, rl);
            check($sformatf("vec%0d_bin", i), rb, vecs[i].bin);
            check($sformatf("vec%0d_err", i), re, vecs[i].err);
            check($sformatf("vec%0d_lat", i), rl, vecs[i].lat);
        end

        convert(1, 16'h0300, rb, re, rl);
        check("n8_ovf_err", re, 1);
        check("n8_ovf_bin", rb, 0);
        check("n8_ovf_lat", rl, 8);
        convert(1, 16'h0255, rb, re, rl);
        check("n8_255_bin", rb, 255);
        check("n8_255_err", re, 0);

        for (int i = 0; i < 24; i++) begin
            for (int d = 0; d < 4; d++)
                v[4*d +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0)
                v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(0, 15));
            model(v, (i % 2) ? 8 : 14, eb, ee, el);
            convert(i % 2, v, rb, re, rl);
            check($sformatf("rnd%0d_%h_bin", i, v), rb, eb);
            check($sformatf("rnd%0d_%h_err", i, v), re, ee);
            check($sformatf("rnd%0d_%h_lat", i, v), rl, el);
        end

        convert(0, 16'h0042, rb, re, rl);
        @(negedge clk);
        start_a = 1'b1;
        bcd_a   = 16'h0123;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_bin", bin_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_done", done_a, 0);
        check("arst_err", err_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done_a) dcnt++;
        end
        check("arst_no_done", dcnt, 0);
        convert(0, 16'h0777, rb, re, rl);
        check("post_rst_bin", rb, 777);
        check("post_rst_err", re, 0);

        @(negedge clk);
        start_a = 1'b1;
        bcd_a   = 16'h0500;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                dpos.push_back(c);
                check("held_bin", bin_a, 500);
                check("held_err", err_a, 0);
            end
        end
        start_a = 1'b0;
        check("held_first_lat", dpos.size() > 0 ? dpos[0] : -1, 14);
        check("held_pulses", dpos.size(), 4);
        for (int i = 1; i < dpos.size(); i++)
            check("held_period", dpos[i] - dpos[i-1], 16);
        for (int i = 0; i < 40 && busy_a; i++) @(posedge clk);
        #1;
        check("held_idle", busy_a, 0);

        @(negedge clk);
        start_a = 1'b1;
        bcd_a   = 16'h0042;
        dcnt    = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done_a) dcnt++;
            start_a = (c == 3 || c == 8);
            bcd_a   = (c == 3 || c == 8) ? 16'h0999 : 16'h0042;
        end
        start_a = 1'b0;
        check("busy_start_ignored", dcnt, 1);
        check("busy_start_bin", bin_a, 42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
